// File: rtl/round_seq.sv
// round_seq: multi-cycle AES encryption round sequencer.
// One request at a time walks SubBytes -> ShiftRows -> MixColumns, each stage
// held for a programmable number of cycles. MixColumns is skipped in final-round
// mode. The result is combined with the on-the-fly expanded round key and held
// until the consumer accepts it.
module round_seq #(
    parameter int unsigned SB_DLY  = 6,
    parameter int unsigned SR_DLY  = 6,
    parameter int unsigned MC_DLY  = 6,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LAST_RC = 10
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   rc,
    input  logic [127:0] data,
    input  logic [127:0] keyin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] rndout,
    output logic [127:0] keyout,
    output logic         out_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SB   = 3'd1;
    localparam logic [2:0] S_SR   = 3'd2;
    localparam logic [2:0] S_MC   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CNT_W-1:0] SB_LD   = CNT_W'(SB_DLY - 1);
    localparam logic [CNT_W-1:0] SR_LD   = CNT_W'(SR_DLY - 1);
    localparam logic [CNT_W-1:0] MC_LD   = CNT_W'(MC_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       LAST4   = LAST_RC[3:0];

    // ------------------------------------------------------------------
    // GF(2^8) and AES transform helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
               {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Round constant: 01 doubled (r-1) times; rc 0 behaves like rc 1.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 1; i < 16; i++)
            if (i < int'(r)) v = xtime(v);
        return v;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(r), 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             fin;      // last stage captured; outputs load next edge
    logic [127:0]     work;     // captured data, then each stage's result
    logic [127:0]     key_q;
    logic [3:0]       rc_q;

    logic             accept;
    logic             sb_cap;
    logic             sr_cap;
    logic             mc_cap;
    logic             final_q;
    logic             err_q;
    logic [127:0]     key_nxt;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign sb_cap   = (state == S_SB) && (cnt == '0);
    assign sr_cap   = (state == S_SR) && (cnt == '0) && !fin;
    assign mc_cap   = (state == S_MC) && (cnt == '0) && !fin;
    assign final_q  = (rc_q == LAST4);
    assign err_q    = (rc_q == 4'd0) || (rc_q > LAST4);
    assign key_nxt  = key_exp(key_q, rc_q);

    // Sequencer: stage timing, result registration and output handshake.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= S_IDLE;
            cnt       <= '0;
            fin       <= 1'b0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            rndout    <= '0;
            keyout    <= '0;
        end else if (fin) begin
            fin       <= 1'b0;
            state     <= S_DONE;
            out_valid <= 1'b1;
            keyout    <= key_nxt;
            rndout    <= key_nxt ^ work;
            out_err   <= err_q;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_SB;
                        cnt   <= SB_LD;
                    end
                end
                S_SB: begin
                    if (cnt == '0) begin
                        state <= S_SR;
                        cnt   <= SR_LD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_SR: begin
                    if (cnt == '0) begin
                        if (final_q) begin
                            fin <= 1'b1;
                        end else begin
                            state <= S_MC;
                            cnt   <= MC_LD;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_MC: begin
                    if (cnt == '0) fin <= 1'b1;
                    else           cnt <= cnt - CNT_ONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: request capture and per-stage transform results.
    // NOTE: these registers have no reset; they are always written by a
    // handshake before any stage or output reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            work  <= data;
            key_q <= keyin;
            rc_q  <= rc;
        end else if (sb_cap) begin
            work <= sub_bytes(work);
        end else if (sr_cap) begin
            work <= shift_rows(work);
        end else if (mc_cap) begin
            work <= mix_columns(work);
        end
    end

endmodule

// File: tb/tb_round_seq.sv
// tb_round_seq: directed FIPS-197 vectors, backpressure, mid-operation reset and
// a fast-timing instance, followed by randomized requests checked against a
// behavioural AES round model.
module tb_round_seq;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: default timing. Instance B: all stage delays 1.
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [3:0]   a_rc;
    logic [127:0] a_data, a_key, a_rndout, a_keyout;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [3:0]   b_rc;
    logic [127:0] b_data, b_key, b_rndout, b_keyout;

    round_seq u_a (
        .clk(clk), .rst_(rst_), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .rc(a_rc), .data(a_data), .keyin(a_key), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .rndout(a_rndout), .keyout(a_keyout),
        .out_err(a_out_err)
    );

    round_seq #(.SB_DLY(1), .SR_DLY(1), .MC_DLY(1)) u_b (
        .clk(clk), .rst_(rst_), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .rc(b_rc), .data(b_data), .keyin(b_key), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .rndout(b_rndout), .keyout(b_keyout),
        .out_err(b_out_err)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [7:0] sbox_t [256];
    logic [7:0] rcon_t [16] = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d, 8'h9a};

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int x;
        p = 0;
        x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
        end
        return p[7:0];
    endfunction

    // S-box from its definition: brute-force inverse, then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^
                       inv[(i+7)%8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [127:0] m_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] m_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[127-8*((i + 4*(i%4)) % 16) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = m_mul(8'h02, a[r]) ^ m_mul(8'h03, a[(r+1)%4]) ^
                                        a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    function automatic logic [127:0] m_key(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {sbox_t[w[3][23:16]], sbox_t[w[3][15:8]], sbox_t[w[3][7:0]], sbox_t[w[3][31:24]]};
        t = t ^ {rcon_t[r], 24'h0};
        w[0] = w[0] ^ t;
        for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic m_round(input logic [3:0] r, input logic [127:0] d, input logic [127:0] k,
                           output logic [127:0] rnd, output logic [127:0] key,
                           output logic err);
        logic [127:0] s;
        s = m_shift(m_sub(d));
        if (r != 4'd10) s = m_mix(s);
        key = m_key(k, r);
        rnd = key ^ s;
        err = (r == 4'd0) || (r > 4'd10);
    endtask

    // ------------------------------------------------------------------
    // Access helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ov(input bit sel);
        return sel ? b_out_valid : a_out_valid;
    endfunction
    function automatic logic get_ir(input bit sel);
        return sel ? b_in_ready : a_in_ready;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? b_out_err : a_out_err;
    endfunction
    function automatic logic [127:0] get_rnd(input bit sel);
        return sel ? b_rndout : a_rndout;
    endfunction
    function automatic logic [127:0] get_key(input bit sel);
        return sel ? b_keyout : a_keyout;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_in(input bit sel, input logic v, input logic [3:0] r,
                          input logic [127:0] d, input logic [127:0] k);
        if (sel) begin
            b_in_valid = v; b_rc = r; b_data = d; b_key = k;
        end else begin
            a_in_valid = v; a_rc = r; a_data = d; a_key = k;
        end
    endtask

    task automatic set_ordy(input bit sel, input logic v);
        if (sel) b_out_ready = v;
        else     a_out_ready = v;
    endtask

    // Offer one request; returns #1 after the accepting edge with inputs scrambled.
    task automatic issue(input bit sel, input logic [3:0] r, input logic [127:0] d,
                         input logic [127:0] k);
        @(negedge clk);
        check("in_ready_idle", 128'(get_ir(sel)), 128'(1'b1));
        set_in(sel, 1'b1, r, d, k);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 4'($urandom), rnd128(), rnd128());
    endtask

    // Count edges until out_valid; optionally toggle inputs meanwhile.
    task automatic wait_out(input bit sel, input bit noisy, output int lat);
        lat = 0;
        while (!get_ov(sel) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (noisy) set_in(sel, 1'($urandom), 4'($urandom), rnd128(), rnd128());
        end
        set_in(sel, 1'b0, 4'($urandom), rnd128(), rnd128());
    endtask

    task automatic retire(input bit sel, input int hold);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        set_ordy(sel, 1'b1);
        @(posedge clk);
        #1;
        check("ov_drop_on_accept", 128'(get_ov(sel)), 128'(1'b0));
        check("in_ready_after_accept", 128'(get_ir(sel)), 128'(1'b1));
        set_ordy(sel, 1'b0);
    endtask

    task automatic txn(input bit sel, input logic [3:0] r, input logic [127:0] d,
                       input logic [127:0] k, input bit noisy);
        logic [127:0] e_rnd, e_key;
        logic         e_err;
        int           lat, e_lat;
        m_round(r, d, k, e_rnd, e_key, e_err);
        e_lat = (r == 4'd10) ? (sel ? 3 : 13) : (sel ? 4 : 19);
        issue(sel, r, d, k);
        wait_out(sel, noisy, lat);
        check("rand_latency", 128'(lat), 128'(e_lat));
        check("rand_rndout", get_rnd(sel), e_rnd);
        check("rand_keyout", get_key(sel), e_key);
        check("rand_err", 128'(get_err(sel)), 128'(e_err));
        retire(sel, int'($urandom_range(0, 3)));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    localparam logic [127:0] D1 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KO1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RO1 = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] D2 = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] K2 = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] KO2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RO2 = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        int           lat;
        logic [127:0] d, e_rnd, e_key;
        logic         e_err;

        build_sbox();
        rst_ = 1'b0;
        set_in(1'b0, 1'b0, 4'd0, '0, '0);
        set_in(1'b1, 1'b0, 4'd0, '0, '0);
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        #1;
        check("rst_out_valid", 128'(a_out_valid), 128'(1'b0));
        check("rst_rndout", a_rndout, '0);
        check("rst_keyout", a_keyout, '0);
        check("rst_out_err", 128'(a_out_err), 128'(1'b0));
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_post_reset", 128'(a_in_ready), 128'(1'b1));

        // Check 1: FIPS-197 round 1.
        issue(1'b0, 4'd1, D1, K1);
        wait_out(1'b0, 1'b1, lat);
        check("c1_latency", 128'(lat), 128'd19);
        check("c1_keyout", a_keyout, KO1);
        check("c1_rndout", a_rndout, RO1);
        check("c1_err", 128'(a_out_err), 128'(1'b0));
        retire(1'b0, 0);

        // Check 2: final round, then hold it under backpressure (check 3).
        issue(1'b0, 4'd10, D2, K2);
        wait_out(1'b0, 1'b0, lat);
        check("c2_latency", 128'(lat), 128'd13);
        check("c2_keyout", a_keyout, KO2);
        check("c2_rndout", a_rndout, RO2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(1'b0, 1'b1, 4'd1, rnd128(), rnd128());
            check("bp_in_ready", 128'(a_in_ready), 128'(1'b0));
            @(posedge clk);
            #1;
            check("bp_out_valid", 128'(a_out_valid), 128'(1'b1));
            check("bp_rndout", a_rndout, RO2);
            check("bp_keyout", a_keyout, KO2);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 4'd0, '0, '0);
        retire(1'b0, 0);

        // Check 4: reset pulse while in ShiftRows, then a clean rerun.
        issue(1'b0, 4'd1, D1, K1);
        repeat (8) @(posedge clk);
        #1;
        rst_ = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(a_out_valid), 128'(1'b0));
        check("mid_rst_in_ready", 128'(a_in_ready), 128'(1'b1));
        check("mid_rst_rndout", a_rndout, '0);
        @(negedge clk);
        rst_ = 1'b1;
        issue(1'b0, 4'd1, D1, K1);
        wait_out(1'b0, 1'b0, lat);
        check("c4_latency", 128'(lat), 128'd19);
        check("c4_rndout", a_rndout, RO1);
        check("c4_keyout", a_keyout, KO1);
        retire(1'b0, 1);

        // Check 5: unit stage delays.
        issue(1'b1, 4'd1, D1, K1);
        wait_out(1'b1, 1'b1, lat);
        check("c5_latency", 128'(lat), 128'd4);
        check("c5_rndout", b_rndout, RO1);
        check("c5_keyout", b_keyout, KO1);
        retire(1'b1, 0);
        d = rnd128();
        m_round(4'd12, d, K1, e_rnd, e_key, e_err);
        issue(1'b1, 4'd12, d, K1);
        wait_out(1'b1, 1'b0, lat);
        check("c5_rc12_latency", 128'(lat), 128'd4);
        check("c5_rc12_err", 128'(b_out_err), 128'(1'b1));
        check("c5_rc12_rndout", b_rndout, e_rnd);
        retire(1'b1, 0);

        // Randomized requests against the model.
        for (int n = 0; n < 24; n++)
            txn(1'b0, 4'($urandom_range(0, 15)), rnd128(), rnd128(), 1'b1);
        for (int n = 0; n < 8; n++)
            txn(1'b1, 4'($urandom_range(0, 15)), rnd128(), rnd128(), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
